// File: rtl/l1c_pkg.sv
// Shared types and helpers for the L1 data cache and its memory-side responder.
// Cache type codes match the D_type encoding used across the cache unit.
package l1c_pkg;

  typedef enum logic [2:0] {
    CT_BYTE    = 3'b000,
    CT_HWORD   = 3'b001,
    CT_WORD    = 3'b010,
    CT_BYTE_U  = 3'b100,
    CT_HWORD_U = 3'b101
  } cache_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } resp_state_e;

  // Unknown codes fold to WORD so every downstream decode stays total.
  function automatic cache_type_e decode_type(input logic [2:0] t);
    cache_type_e r;
    case (t)
      3'b000:  r = CT_BYTE;
      3'b001:  r = CT_HWORD;
      3'b100:  r = CT_BYTE_U;
      3'b101:  r = CT_HWORD_U;
      default: r = CT_WORD;
    endcase
    return r;
  endfunction

  // Active-low byte write enables for a store of type t at byte offset a.
  function automatic logic [3:0] lane_mask(input cache_type_e t, input logic [1:0] a);
    logic [3:0] m;
    case (t)
      CT_BYTE, CT_BYTE_U: begin
        m    = 4'hF;
        m[a] = 1'b0;
      end
      CT_HWORD, CT_HWORD_U: m = a[1] ? 4'b0011 : 4'b1100;
      default:              m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic misaligned(input cache_type_e t, input logic [1:0] a);
    logic r;
    case (t)
      CT_HWORD, CT_HWORD_U: r = a[0];
      CT_WORD:              r = (a != 2'b00);
      default:              r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/l1c_load_format.sv
// Load data alignment: shifts the addressed lane down to bit 0 and extends
// it according to the access type. Purely combinational.
module l1c_load_format
  import l1c_pkg::*;
(
  input  cache_type_e type_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [31:0] sh;

  assign sh = rdata_i >> {off_i, 3'b000};

  always_comb begin
    data_o = sh;
    case (type_i)
      CT_BYTE:    data_o = {{24{sh[7]}}, sh[7:0]};
      CT_BYTE_U:  data_o = {24'h000000, sh[7:0]};
      CT_HWORD:   data_o = {{16{sh[15]}}, sh[15:0]};
      CT_HWORD_U: data_o = {16'h0000, sh[15:0]};
      default:    data_o = sh;
    endcase
  end

endmodule

// File: rtl/l1c_mem_responder.sv
// Memory-side responder for the L1 data cache D_* interface: one request at a
// time, serviced against a single-port synchronous word SRAM after LATENCY cycles.
module l1c_mem_responder
  import l1c_pkg::*;
#(
  parameter int unsigned LATENCY       = 2,
  parameter int unsigned MEM_ADDR_BITS = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     D_req,
  input  logic [31:0]              D_addr,
  input  logic                     D_write,
  input  logic [31:0]              D_in,
  input  logic [2:0]               D_type,
  output logic [31:0]              D_out,
  output logic                     D_wait,
  output logic                     D_err,
  output logic                     mem_cs,
  output logic                     mem_oe,
  output logic [3:0]               mem_web,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic [31:0]              mem_di,
  input  logic [31:0]              mem_do
);

  localparam int unsigned AW = MEM_ADDR_BITS + 2;

  resp_state_e state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q;
  logic          write_q;
  logic [31:0]   data_q;
  cache_type_e   type_q;
  logic [31:0]   dout_q;
  logic          capture;
  logic          mis;
  logic [31:0]   fmt;
  logic          unused_addr_hi;

  // Upper address bits alias onto the SRAM and are deliberately dropped.
  assign unused_addr_hi = ^D_addr[31:AW];

  assign mis      = misaligned(type_q, addr_q[1:0]);
  assign mem_addr = addr_q[AW-1:2];
  assign mem_di   = data_q << {addr_q[1:0], 3'b000};

  l1c_load_format u_fmt (
    .type_i  (type_q),
    .off_i   (addr_q[1:0]),
    .rdata_i (mem_do),
    .data_o  (fmt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      data_q  <= '0;
      type_q  <= CT_WORD;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        addr_q  <= D_addr[AW-1:0];
        write_q <= D_write;
        data_q  <= D_in;
        type_q  <= decode_type(D_type);
      end
      if (state_q == ST_RESP) dout_q <= D_out;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (D_req) begin
          capture = 1'b1;
          cnt_d   = 4'(LATENCY);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // SRAM strobes are gated by rst so an aborted write never reaches the array.
  always_comb begin
    D_wait  = 1'b0;
    D_err   = 1'b0;
    D_out   = dout_q;
    mem_cs  = 1'b0;
    mem_oe  = 1'b0;
    mem_web = 4'hF;
    case (state_q)
      ST_IDLE: D_wait = D_req;
      ST_WAIT: begin
        D_wait = 1'b1;
        if (cnt_q == 4'd1 && !mis && !rst) begin
          mem_cs = 1'b1;
          if (write_q) mem_web = lane_mask(type_q, addr_q[1:0]);
          else         mem_oe  = 1'b1;
        end
      end
      ST_RESP: begin
        D_err = mis;
        if (mis)           D_out = '0;
        else if (!write_q) D_out = fmt;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_l1c_mem_responder.sv
// Directed bench for l1c_mem_responder with a behavioural word SRAM and
// hand-computed expected values.
module tb_l1c_mem_responder;

  localparam logic [2:0] T_BYTE    = 3'b000;
  localparam logic [2:0] T_HWORD   = 3'b001;
  localparam logic [2:0] T_WORD    = 3'b010;
  localparam logic [2:0] T_BYTE_U  = 3'b100;
  localparam logic [2:0] T_HWORD_U = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic        D_req;
  logic [31:0] D_addr;
  logic        D_write;
  logic [31:0] D_in;
  logic [2:0]  D_type;
  logic [31:0] D_out;
  logic        D_wait;
  logic        D_err;
  logic        mem_cs;
  logic        mem_oe;
  logic [3:0]  mem_web;
  logic [13:0] mem_addr;
  logic [31:0] mem_di;
  logic [31:0] mem_do;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sram [0:16383];

  always #5 clk = ~clk;

  l1c_mem_responder #(.LATENCY(2), .MEM_ADDR_BITS(14)) dut (
    .clk      (clk),
    .rst      (rst),
    .D_req    (D_req),
    .D_addr   (D_addr),
    .D_write  (D_write),
    .D_in     (D_in),
    .D_type   (D_type),
    .D_out    (D_out),
    .D_wait   (D_wait),
    .D_err    (D_err),
    .mem_cs   (mem_cs),
    .mem_oe   (mem_oe),
    .mem_web  (mem_web),
    .mem_addr (mem_addr),
    .mem_di   (mem_di),
    .mem_do   (mem_do)
  );

  always @(posedge clk) begin
    if (mem_cs && mem_oe) mem_do <= sram[mem_addr];
    if (mem_cs) begin
      for (int i = 0; i < 4; i++)
        if (!mem_web[i]) sram[mem_addr][8*i +: 8] <= mem_di[8*i +: 8];
    end
  end

  // Requester must hold D_req while the responder reports busy.
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (prev_busy && !rst) assert (D_req) else $error("D_req dropped while D_wait high");
    prev_busy <= D_wait && !rst;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request starting just after a posedge; returns at posedge+1 after completion.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] t, output logic [31:0] dout, output logic err,
                     output int cycles, output logic cs_seen, output logic [3:0] web_seen,
                     output logic [31:0] di_seen, output logic [13:0] addr_seen);
    bit done = 0;
    D_req = 1'b1; D_write = w; D_addr = a; D_in = d; D_type = t;
    cycles = 0; cs_seen = 0; web_seen = 4'hF; di_seen = '0; addr_seen = '0;
    dout = '0; err = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (D_wait) begin
        cycles++;
        if (mem_cs) begin
          cs_seen   = 1;
          web_seen  = web_seen & mem_web;
          di_seen   = mem_di;
          addr_seen = mem_addr;
        end
      end else begin
        dout = D_out;
        err  = D_err;
        done = 1;
      end
    end
    if (!done) check_eq("txn_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic go_idle();
    D_req = 1'b0;
  endtask

  logic [31:0] dout, di;
  logic        err, cs;
  logic [3:0]  web;
  logic [13:0] ma;
  int          cyc;
  logic [3:0]  web_acc;
  logic        cs_acc;

  initial begin
    for (int i = 0; i < 16384; i++) sram[i] = '0;
    mem_do = '0;
    rst = 1'b1; D_req = 0; D_addr = '0; D_write = 0; D_in = '0; D_type = T_WORD;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_wait", {31'd0, D_wait}, 32'd0);
    check_eq("rst_web",  {28'd0, mem_web}, 32'hF);
    check_eq("rst_cs",   {31'd0, mem_cs}, 32'd0);
    check_eq("rst_dout", D_out, 32'd0);
    check_eq("rst_err",  {31'd0, D_err}, 32'd0);
    @(posedge clk); #1;

    txn(1, 32'h40, 32'hDEADBEEF, T_WORD, dout, err, cyc, cs, web, di, ma);
    check_eq("ww_web",   {28'd0, web}, 32'h0);
    check_eq("ww_addr",  {18'd0, ma}, 32'h10);
    check_eq("ww_di",    di, 32'hDEADBEEF);
    check_eq("ww_cycles", cyc, 3);
    check_eq("ww_dout_hold", dout, 32'd0);
    go_idle(); @(posedge clk); #1;
    txn(0, 32'h40, 32'h0, T_WORD, dout, err, cyc, cs, web, di, ma);
    check_eq("wr_dout",   dout, 32'hDEADBEEF);
    check_eq("wr_cycles", cyc, 3);
    check_eq("wr_err",    {31'd0, err}, 32'd0);

    txn(1, 32'h43, 32'h80, T_BYTE, dout, err, cyc, cs, web, di, ma);
    check_eq("bw_web",  {28'd0, web}, 32'h7);
    check_eq("bw_di",   di, 32'h80000000);
    check_eq("bw_dout_hold", dout, 32'hDEADBEEF);
    txn(0, 32'h43, 32'h0, T_BYTE, dout, err, cyc, cs, web, di, ma);
    check_eq("br_dout", dout, 32'hFFFFFF80);
    txn(0, 32'h43, 32'h0, T_BYTE_U, dout, err, cyc, cs, web, di, ma);
    check_eq("bur_dout", dout, 32'h00000080);
    txn(0, 32'h41, 32'h0, T_BYTE, dout, err, cyc, cs, web, di, ma);
    check_eq("br1_dout", dout, 32'hFFFFFFBE);

    txn(1, 32'h46, 32'h8001, T_HWORD, dout, err, cyc, cs, web, di, ma);
    check_eq("hw_web", {28'd0, web}, 32'h3);
    check_eq("hw_di",  di, 32'h80010000);
    check_eq("hw_addr", {18'd0, ma}, 32'h11);
    txn(0, 32'h46, 32'h0, T_HWORD, dout, err, cyc, cs, web, di, ma);
    check_eq("hr_dout", dout, 32'hFFFF8001);
    txn(0, 32'h46, 32'h0, T_HWORD_U, dout, err, cyc, cs, web, di, ma);
    check_eq("hur_dout", dout, 32'h00008001);

    txn(0, 32'h41, 32'h0, T_WORD, dout, err, cyc, cs, web, di, ma);
    check_eq("mis_cs",     {31'd0, cs}, 32'd0);
    check_eq("mis_err",    {31'd0, err}, 32'd1);
    check_eq("mis_dout",   dout, 32'd0);
    check_eq("mis_cycles", cyc, 3);
    txn(0, 32'h40, 32'h0, T_WORD, dout, err, cyc, cs, web, di, ma);
    check_eq("b2b_dout",   dout, 32'h80ADBEEF);
    check_eq("b2b_err",    {31'd0, err}, 32'd0);
    check_eq("b2b_cycles", cyc, 3);
    txn(0, 32'h45, 32'h0, T_HWORD_U, dout, err, cyc, cs, web, di, ma);
    check_eq("mish_err",  {31'd0, err}, 32'd1);
    check_eq("mish_cs",   {31'd0, cs}, 32'd0);
    txn(0, 32'h44, 32'h0, 3'b011, dout, err, cyc, cs, web, di, ma);
    check_eq("undef_dout", dout, 32'h80010000);
    txn(0, 32'h1_0044, 32'h0, T_WORD, dout, err, cyc, cs, web, di, ma);
    check_eq("alias_dout", dout, 32'h80010000);
    go_idle(); @(posedge clk); #1;

    // Abort a write with rst on the cycle its SRAM access would issue.
    D_req = 1; D_write = 1; D_addr = 32'h44; D_in = 32'h12345678; D_type = T_WORD;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; D_req = 0;
    @(negedge clk);
    check_eq("abort_web", {28'd0, mem_web}, 32'hF);
    check_eq("abort_cs",  {31'd0, mem_cs}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    web_acc = 4'hF; cs_acc = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      web_acc = web_acc & mem_web;
      cs_acc  = cs_acc | mem_cs;
    end
    check_eq("post_web",  {28'd0, web_acc}, 32'hF);
    check_eq("post_cs",   {31'd0, cs_acc}, 32'd0);
    check_eq("post_wait", {31'd0, D_wait}, 32'd0);
    @(posedge clk); #1;
    txn(0, 32'h44, 32'h0, T_WORD, dout, err, cyc, cs, web, di, ma);
    check_eq("abort_read", dout, 32'h80010000);
    check_eq("abort_read_cycles", cyc, 3);
    go_idle();
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
